// File: rtl/io_bank_pkg.sv
// io_bank_pkg: register offsets, register-select enum and decode helper
// shared by the io_bank_mmio top and its sub-module.
package io_bank_pkg;

    localparam logic [4:0] IO_OFS_IN   = 5'h00;
    localparam logic [4:0] IO_OFS_OUT  = 5'h04;
    localparam logic [4:0] IO_OFS_SET  = 5'h08;
    localparam logic [4:0] IO_OFS_CLR  = 5'h0C;
    localparam logic [4:0] IO_OFS_EDGE = 5'h10;
    localparam logic [4:0] IO_OFS_MASK = 5'h14;
    localparam logic [4:0] IO_OFS_POL  = 5'h18;

    localparam logic [31:0] IO_POL_RESET = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IO_REG_IN,
        IO_REG_OUT,
        IO_REG_SET,
        IO_REG_CLR,
        IO_REG_EDGE,
        IO_REG_MASK,
        IO_REG_POL,
        IO_REG_NONE
    } io_reg_e;

    // ofs is the word-aligned distance from BASE_ADDR; negative wraps high.
    function automatic io_reg_e io_decode(
        input logic [31:0] ofs,
        input logic        edge_en
    );
        io_reg_e sel;
        sel = IO_REG_NONE;
        if (ofs[31:5] == '0) begin
            case (ofs[4:0])
                IO_OFS_IN:   sel = IO_REG_IN;
                IO_OFS_OUT:  sel = IO_REG_OUT;
                IO_OFS_SET:  sel = IO_REG_SET;
                IO_OFS_CLR:  sel = IO_REG_CLR;
                IO_OFS_EDGE: if (edge_en) sel = IO_REG_EDGE;
                IO_OFS_MASK: if (edge_en) sel = IO_REG_MASK;
                IO_OFS_POL:  if (edge_en) sel = IO_REG_POL;
                default:     sel = IO_REG_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/io_sync_edge.sv
// io_sync_edge: input synchronizer chain plus, when IO_BANK_EDGE_IRQ_EN is
// defined, the prev/primed tracking and polarity-qualified edge pulses.
module io_sync_edge
    import io_bank_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_in,
    input  logic [W-1:0] i_pol,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_edge
);

    logic [STAGES-1:0][W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_in};
        end
    end

    assign o_sync = r_sync[STAGES-1];

`ifdef IO_BANK_EDGE_IRQ_EN
    logic [W-1:0] r_prev;
    logic [2:0]   r_cnt;
    logic         r_primed;
    logic [W-1:0] w_rise;
    logic [W-1:0] w_fall;

    // primed rises once the reset zeros have drained out of chain and prev
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev   <= '0;
            r_cnt    <= '0;
            r_primed <= 1'b0;
        end else begin
            r_prev <= o_sync;
            if (!r_primed) begin
                r_cnt    <= r_cnt + 3'd1;
                r_primed <= (r_cnt == 3'(STAGES));
            end
        end
    end

    assign w_rise = o_sync & ~r_prev;
    assign w_fall = ~o_sync & r_prev;
    assign o_edge = r_primed ? ((i_pol & w_rise) | (~i_pol & w_fall)) : '0;
`else
    logic w_unused_pol;
    assign w_unused_pol = ^i_pol;
    assign o_edge       = '0;
`endif

endmodule

// File: rtl/io_bank_mmio.sv
// io_bank_mmio: memory-mapped switch/LED bank with set/clear output port.
// Edge capture, mask, polarity and irq exist only with IO_BANK_EDGE_IRQ_EN.
module io_bank_mmio
    import io_bank_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4,
    parameter int          IN_W        = 8,
    parameter int          OUT_W       = 8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             hit,
    input  logic [IN_W-1:0]  io_in,
    output logic [OUT_W-1:0] io_out,
    output logic             irq
);

`ifdef IO_BANK_EDGE_IRQ_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    logic [31:0]      w_ofs;
    io_reg_e          w_sel;
    logic             w_wr_out;
    logic             w_wr_set;
    logic             w_wr_clr;
    logic             w_wr_edge;
    logic             w_wr_mask;
    logic             w_wr_pol;
    logic [OUT_W-1:0] w_wd_out;
    logic [IN_W-1:0]  w_wd_in;
    logic [IN_W-1:0]  w_in;
    logic [IN_W-1:0]  w_edge;
    logic [IN_W-1:0]  w_pol;
    logic [IN_W-1:0]  w_edge_rd;
    logic [IN_W-1:0]  w_mask_rd;
    logic [IN_W-1:0]  w_pol_rd;
    logic [OUT_W-1:0] r_out;
    logic             w_unused;

    assign w_ofs = {addr[31:2], 2'b00} - BASE_ADDR;
    assign w_sel = io_decode(w_ofs, EDGE_EN);
    assign hit   = (w_sel != IO_REG_NONE);

    assign w_wr_out  = we && (w_sel == IO_REG_OUT);
    assign w_wr_set  = we && (w_sel == IO_REG_SET);
    assign w_wr_clr  = we && (w_sel == IO_REG_CLR);
    assign w_wr_edge = we && (w_sel == IO_REG_EDGE);
    assign w_wr_mask = we && (w_sel == IO_REG_MASK);
    assign w_wr_pol  = we && (w_sel == IO_REG_POL);

    assign w_wd_out = wdata[OUT_W-1:0];
    assign w_wd_in  = wdata[IN_W-1:0];

    io_sync_edge #(
        .W      (IN_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .i_in   (io_in),
        .i_pol  (w_pol),
        .o_sync (w_in),
        .o_edge (w_edge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else if (w_wr_out) begin
            r_out <= w_wd_out;
        end else if (w_wr_set) begin
            r_out <= r_out | w_wd_out;
        end else if (w_wr_clr) begin
            r_out <= r_out & ~w_wd_out;
        end
    end

    assign io_out = r_out;

`ifdef IO_BANK_EDGE_IRQ_EN
    logic [IN_W-1:0] r_edge;
    logic [IN_W-1:0] r_mask;
    logic [IN_W-1:0] r_pol;
    logic            r_irq;
    logic [IN_W-1:0] w_w1c;

    assign w_w1c = w_wr_edge ? w_wd_in : '0;

    // OR-ing the new pulses after the clear lets a same-cycle edge survive W1C
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge <= '0;
            r_mask <= '0;
            r_pol  <= IO_POL_RESET[IN_W-1:0];
            r_irq  <= 1'b0;
        end else begin
            r_edge <= (r_edge & ~w_w1c) | w_edge;
            r_irq  <= |(r_edge & r_mask);
            if (w_wr_mask) r_mask <= w_wd_in;
            if (w_wr_pol)  r_pol  <= w_wd_in;
        end
    end

    assign w_pol     = r_pol;
    assign w_edge_rd = r_edge;
    assign w_mask_rd = r_mask;
    assign w_pol_rd  = r_pol;
    assign irq       = r_irq;
    assign w_unused  = ^{addr[1:0], wdata};
`else
    assign w_pol     = IO_POL_RESET[IN_W-1:0];
    assign w_edge_rd = '0;
    assign w_mask_rd = '0;
    assign w_pol_rd  = '0;
    assign irq       = 1'b0;
    assign w_unused  = ^{addr[1:0], wdata, w_edge, w_wr_edge,
                         w_wr_mask, w_wr_pol};
`endif

    always_comb begin
        rdata = '0;
        case (w_sel)
            IO_REG_IN:   rdata = 32'(w_in);
            IO_REG_OUT:  rdata = 32'(r_out);
            IO_REG_SET:  rdata = 32'(r_out);
            IO_REG_CLR:  rdata = 32'(r_out);
            IO_REG_EDGE: rdata = 32'(w_edge_rd);
            IO_REG_MASK: rdata = 32'(w_mask_rd);
            IO_REG_POL:  rdata = 32'(w_pol_rd);
            default:     rdata = '0;
        endcase
    end

endmodule
